// File: rtl/soc_system_edge_pio.sv
// Avalon-MM input PIO: synchronised inputs, per-bit rise/fall edge capture (W1C), maskable level IRQ,
// saturating event counter and post-reset arming. Optional debounce when SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN is defined.
module soc_system_edge_pio #(
   parameter int               WIDTH           = 4,
   parameter int               SYNC_STAGES     = 2,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] FALL_EN_RESET   = '1,
   parameter logic [WIDTH-1:0] RISE_EN_RESET   = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);

   typedef enum logic [2:0] {
      ADDR_DATA    = 3'd0,
      ADDR_RISE_EN = 3'd1,
      ADDR_MASK    = 3'd2,
      ADDR_CAPTURE = 3'd3,
      ADDR_FALL_EN = 3'd4,
      ADDR_COUNT   = 3'd5
   } reg_addr_e;

   localparam int ARM_COUNT = SYNC_STAGES + 1;
   localparam int ARM_W     = $clog2(ARM_COUNT + 1);

   if (WIDTH < 1 || WIDTH > 32 || SYNC_STAGES < 2 || SYNC_STAGES > 3 || DEBOUNCE_CYCLES < 2) begin : g_param_error
      $error("soc_system_edge_pio: parameter out of range");
   end

   logic [WIDTH-1:0] sync [SYNC_STAGES];
   logic [WIDTH-1:0] sync_last;
   logic [WIDTH-1:0] cond;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_capture;
   logic [WIDTH-1:0] edge_hit;
   logic [WIDTH-1:0] capture_clr;
   logic [7:0]       event_count;
   logic [ARM_W-1:0] arm_cnt;
   logic             armed;
   logic             wr;
   logic [31:0]      rd_mux;
   logic             unused_bits;

   // Upper write-data bits have no storage behind them.
   assign unused_bits = ^writedata;

   // NOTE: the synchroniser array is reset explicitly; it is a handful of flops, not a RAM.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      end else begin
         sync[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      end
   end

   assign sync_last = sync[SYNC_STAGES-1];
   assign armed     = (arm_cnt == ARM_W'(ARM_COUNT));

`ifdef SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

   logic [DB_W-1:0]  db_cnt [WIDTH];
   logic [WIDTH-1:0] cond_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cond_q <= '0;
         for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
      end else if (!armed) begin
         cond_q <= sync_last;
         for (int i = 0; i < WIDTH; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync_last[i] == cond_q[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               cond_q[i] <= sync_last[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Until armed the raw synchroniser output is used, so prev settles before edges are allowed.
   assign cond = armed ? cond_q : sync_last;
`else
   assign cond = sync_last;
`endif

   assign wr          = chipselect & ~write_n;
   assign edge_hit    = armed ? ((rise_en & cond & ~prev) | (fall_en & ~cond & prev)) : '0;
   assign capture_clr = (wr && address == ADDR_CAPTURE) ? writedata[WIDTH-1:0] : '0;
   assign irq         = |(edge_capture & irq_mask);

   // NOTE: every output of a combinational block gets a default first so no latch is inferred.
   always_comb begin
      rd_mux = '0;
      case (address)
         ADDR_DATA:    rd_mux[WIDTH-1:0] = cond;
         ADDR_RISE_EN: rd_mux[WIDTH-1:0] = rise_en;
         ADDR_MASK:    rd_mux[WIDTH-1:0] = irq_mask;
         ADDR_CAPTURE: rd_mux[WIDTH-1:0] = edge_capture;
         ADDR_FALL_EN: rd_mux[WIDTH-1:0] = fall_en;
         ADDR_COUNT:   rd_mux[7:0]       = event_count;
         default:      rd_mux            = '0;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         prev         <= '0;
         arm_cnt      <= '0;
         rise_en      <= RISE_EN_RESET;
         fall_en      <= FALL_EN_RESET;
         irq_mask     <= '0;
         edge_capture <= '0;
         event_count  <= '0;
         readdata     <= '0;
      end else begin
         prev     <= cond;
         readdata <= rd_mux;

         if (!armed) arm_cnt <= arm_cnt + 1'b1;

         // A new edge wins over a simultaneous clear so no event is lost.
         edge_capture <= (edge_capture & ~capture_clr) | edge_hit;

         if (wr && address == ADDR_COUNT)
            event_count <= {7'd0, |edge_hit};
         else if (|edge_hit && event_count != 8'hFF)
            event_count <= event_count + 8'd1;

         if (wr && address == ADDR_RISE_EN) rise_en  <= writedata[WIDTH-1:0];
         if (wr && address == ADDR_MASK)    irq_mask <= writedata[WIDTH-1:0];
         if (wr && address == ADDR_FALL_EN) fall_en  <= writedata[WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_soc_system_edge_pio.sv
// Self-checking bench for soc_system_edge_pio: register table, directed edge/IRQ/counter sequences,
// and a randomized run compared against a history-based reference model.
module tb_soc_system_edge_pio;

   localparam int         W      = 4;
   localparam int         S      = 2;
   localparam logic [3:0] RISE_R = 4'hF;
   localparam logic [3:0] FALL_R = 4'hF;

   logic        clk;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [W-1:0] in_port;
   logic [31:0] readdata;
   logic        irq;

   int total = 0;
   int bad   = 0;

   soc_system_edge_pio #(
      .WIDTH(W),
      .SYNC_STAGES(S),
      .DEBOUNCE_CYCLES(8),
      .FALL_EN_RESET(FALL_R),
      .RISE_EN_RESET(RISE_R)
   ) dut (
      .clk(clk),
      .reset(reset),
      .address(address),
      .chipselect(chipselect),
      .write_n(write_n),
      .writedata(writedata),
      .in_port(in_port),
      .readdata(readdata),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: conditioned value is the input seen S edges ago; edges need S+1 settled edges after reset.
   typedef struct packed {
      logic [W-1:0]           rise;
      logic [W-1:0]           fall;
      logic [W-1:0]           mask;
      logic [W-1:0]           cap;
      logic [7:0]             cnt;
      logic [31:0]            rd;
      logic [15:0]            since;
      logic [S+1:0][W-1:0]    hist;
   } model_t;

   model_t ms;

   function automatic model_t model_step(model_t m, logic rst, logic cs, logic wn, logic [2:0] a,
                                         logic [31:0] wd, logic [W-1:0] pin);
      model_t n;
      logic [W-1:0] cur, old, ev, clr;
      logic wr;
      n = m;
      if (rst) begin
         n.rise = RISE_R; n.fall = FALL_R; n.mask = '0; n.cap = '0;
         n.cnt = '0; n.rd = '0; n.since = '0; n.hist = '0;
      end else begin
         n.hist = {m.hist[S:0], pin};
         if (m.since != 16'hFFFF) n.since = m.since + 16'd1;
         cur = n.hist[S];
         old = n.hist[S+1];
         ev  = (n.since >= 16'(S + 2)) ? ((m.rise & cur & ~old) | (m.fall & ~cur & old)) : '0;
         case (a)
            3'd0:    n.rd = 32'(cur);
            3'd1:    n.rd = 32'(m.rise);
            3'd2:    n.rd = 32'(m.mask);
            3'd3:    n.rd = 32'(m.cap);
            3'd4:    n.rd = 32'(m.fall);
            3'd5:    n.rd = 32'(m.cnt);
            default: n.rd = 32'd0;
         endcase
         wr    = cs & ~wn;
         clr   = (wr && a == 3'd3) ? wd[W-1:0] : '0;
         n.cap = (m.cap & ~clr) | ev;
         if (wr && a == 3'd5)             n.cnt = (ev != 0) ? 8'd1 : 8'd0;
         else if (ev != 0 && m.cnt != 8'd255) n.cnt = m.cnt + 8'd1;
         if (wr && a == 3'd1) n.rise = wd[W-1:0];
         if (wr && a == 3'd2) n.mask = wd[W-1:0];
         if (wr && a == 3'd4) n.fall = wd[W-1:0];
      end
      return n;
   endfunction

   always @(posedge clk)
      ms <= model_step(ms, reset, chipselect, write_n, address, writedata, in_port);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
      address = a;
      @(negedge clk);
      d = readdata;
   endtask

   typedef struct {
      logic [2:0]  addr;
      logic        do_wr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [31:0] d;

      vecs[0]  = '{3'd0, 1'b0, 32'h0,         32'hF};
      vecs[1]  = '{3'd1, 1'b1, 32'hFFFF_FFF5, 32'h5};
      vecs[2]  = '{3'd2, 1'b1, 32'h0000_00A5, 32'h5};
      vecs[3]  = '{3'd4, 1'b1, 32'h0001_0009, 32'h9};
      vecs[4]  = '{3'd0, 1'b1, 32'h0,         32'hF};
      vecs[5]  = '{3'd6, 1'b1, 32'hFFFF,      32'h0};
      vecs[6]  = '{3'd7, 1'b0, 32'h0,         32'h0};
      vecs[7]  = '{3'd3, 1'b1, 32'hF,         32'h0};
      vecs[8]  = '{3'd5, 1'b0, 32'h0,         32'h0};
      vecs[9]  = '{3'd2, 1'b1, 32'h0,         32'h0};
      vecs[10] = '{3'd1, 1'b1, 32'hF,         32'hF};

      reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0; writedata = '0; in_port = 4'hF;
      tick(3);
      check("reset_readdata", readdata, 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      reset = 1'b0;
      tick(20);
      check("armed_irq", 32'(irq), 32'h0);
      bus_read(3'd3, d); check("armed_capture", d, 32'h0);
      bus_read(3'd5, d); check("armed_count", d, 32'h0);
      bus_read(3'd0, d); check("armed_data", d, 32'hF);
      bus_read(3'd1, d); check("reset_rise_en", d, 32'(RISE_R));
      bus_read(3'd2, d); check("reset_mask", d, 32'h0);
      bus_read(3'd4, d); check("reset_fall_en", d, 32'(FALL_R));

      for (int i = 0; i < 11; i++) begin
         if (vecs[i].do_wr) bus_write(vecs[i].addr, vecs[i].wdata);
         bus_read(vecs[i].addr, d);
         check($sformatf("table_%0d", i), d, vecs[i].exp);
      end
      bus_write(3'd4, 32'hF);

`ifndef SOC_SYSTEM_EDGE_PIO_DEBOUNCE_EN
      // Falling edge on bit0 with mask bit0: capture appears exactly S+1 edges later.
      bus_write(3'd2, 32'h1);
      in_port = 4'hE;
      tick(S);
      check("irq_before_latency", 32'(irq), 32'h0);
      tick(1);
      check("irq_at_latency", 32'(irq), 32'h1);
      bus_read(3'd3, d); check("capture_bit0", d, 32'h1);
      bus_write(3'd3, 32'h1);
      check("irq_after_w1c", 32'(irq), 32'h0);

      // Rising-only on bit2.
      bus_write(3'd4, 32'h0);
      bus_write(3'd1, 32'h4);
      bus_write(3'd3, 32'hF);
      bus_write(3'd5, 32'h0);
      in_port = 4'hA; tick(5);
      bus_read(3'd3, d); check("fall_disabled_capture", d, 32'h0);
      bus_read(3'd5, d); check("fall_disabled_count", d, 32'h0);
      in_port = 4'hE; tick(5);
      bus_read(3'd3, d); check("rise_bit2_capture", d, 32'h4);
      bus_read(3'd5, d); check("rise_bit2_count", d, 32'h1);
      in_port = 4'hA; tick(5);
      bus_read(3'd3, d); check("fall_bit2_capture", d, 32'h4);
      bus_read(3'd5, d); check("fall_bit2_count", d, 32'h1);

      // Clear of bit0 in the same cycle its edge is captured: set wins.
      bus_write(3'd4, 32'h1);
      bus_write(3'd3, 32'hF);
      in_port = 4'hB; tick(4);
      bus_read(3'd3, d); check("rise_bit0_ignored", d, 32'h0);
      in_port = 4'hA;
      tick(S);
      bus_write(3'd3, 32'h1);
      check("set_wins_irq", 32'(irq), 32'h1);
      bus_read(3'd3, d); check("set_wins_capture", d, 32'h1);
      bus_write(3'd3, 32'h1);
      check("set_wins_cleared_irq", 32'(irq), 32'h0);

      // Event counter saturation and write/event collision.
      bus_write(3'd4, 32'h2);
      bus_write(3'd5, 32'h0);
      for (int i = 0; i < 300; i++) begin
         in_port = 4'h8; tick(1);
         in_port = 4'hA; tick(1);
      end
      tick(S + 2);
      bus_read(3'd5, d); check("count_saturated", d, 32'd255);
      bus_write(3'd5, 32'h0);
      bus_read(3'd5, d); check("count_cleared", d, 32'd0);
      in_port = 4'h8;
      tick(S);
      bus_write(3'd5, 32'h0);
      bus_read(3'd5, d); check("count_write_with_event", d, 32'd1);

      // Randomized run against the reference model, including mid-run resets.
      for (int c = 0; c < 3000; c++) begin
         check("rand_readdata", readdata, ms.rd);
         check("rand_irq", 32'(irq), 32'(|(ms.cap & ms.mask)));
         reset      = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 2) == 0) in_port = W'($urandom);
         chipselect = 1'($urandom);
         write_n    = ($urandom_range(0, 3) != 0);
         address    = 3'($urandom);
         writedata  = $urandom;
         @(negedge clk);
      end
      reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
      tick(2);
`else
      // Debounce build: a short glitch is filtered, a long stable change is captured.
      bus_write(3'd3, 32'hF);
      in_port = 4'hE; tick(5);
      in_port = 4'hF; tick(15);
      bus_read(3'd0, d); check("glitch_data", d, 32'hF);
      bus_read(3'd3, d); check("glitch_capture", d, 32'h0);
      in_port = 4'hE; tick(20);
      bus_read(3'd0, d); check("stable_data", d, 32'hE);
      bus_read(3'd3, d); check("stable_capture", d, 32'h1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
